// File: rtl/seq_pattern_detector_pkg.sv
// Shared helpers for serial pattern-detector FSMs.
//   clog2()      : ceiling log2 for sizing state registers
//   pat_bit()    : i-th bit of the pattern in arrival order (0 = first received)
//   border()     : length of the longest proper border of a pattern prefix
//   next_state() : KMP transition from state s on input bit b (PAT_W means complete)
//   Mode constants for the MOORE and OVERLAP parameters.
// All functions are meant for elaboration-time use; their results are
// baked into constant transition tables.
package seq_pattern_detector_pkg;

  localparam int MAX_PAT_W = 16;

  localparam bit MODE_MOORE  = 1'b1;
  localparam bit MODE_MEALY  = 1'b0;
  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                   input int pat_w, input int i);
    logic [MAX_PAT_W-1:0] sh;
    if (i < 0 || i >= pat_w) return 1'b0;
    sh = pattern >> (pat_w - 1 - i);
    return sh[0];
  endfunction

  // Longest len < k such that prefix[0..len-1] == prefix[k-len..k-1].
  function automatic int border(input logic [MAX_PAT_W-1:0] pattern,
                                input int pat_w, input int k);
    int   result;
    logic same;
    result = 0;
    for (int len = 1; len < MAX_PAT_W; len++) begin
      if (len < k) begin
        same = 1'b1;
        for (int j = 0; j < MAX_PAT_W; j++) begin
          if (j < len) begin
            if (pat_bit(pattern, pat_w, j) != pat_bit(pattern, pat_w, k - len + j))
              same = 1'b0;
          end
        end
        if (same) result = len;
      end
    end
    return result;
  endfunction

  // Falls back through borders until a prefix extends with b, or reaches 0.
  function automatic int next_state(input logic [MAX_PAT_W-1:0] pattern,
                                    input int pat_w, input int s, input logic b);
    int   t;
    int   result;
    logic done;
    if (s < 0 || s >= pat_w) return 0;
    t      = s;
    result = 0;
    done   = 1'b0;
    for (int iter = 0; iter <= MAX_PAT_W; iter++) begin
      if (!done) begin
        if (pat_bit(pattern, pat_w, t) == b) begin
          result = t + 1;
          done   = 1'b1;
        end else if (t == 0) begin
          result = 0;
          done   = 1'b1;
        end else begin
          t = border(pattern, pat_w, t);
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// sat_counter: saturating event counter.
//   CLK   : clock, rising edge
//   CLR   : synchronous active-high reset
//   inc   : count one event this cycle
//   clr   : synchronous clear of the count; wins over inc
//   count : current count, sticks at all-ones
module sat_counter
  import seq_pattern_detector_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK) begin
    if (CLR || clr) count <= '0;
    else if (inc)   count <= sat_inc(count);
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial KMP pattern detector with saturating match counter.
//   CLK         : clock, rising edge
//   CLR         : synchronous active-high reset
//   en          : sample x_in this cycle
//   x_in        : serial data bit (pattern MSB arrives first)
//   clr_count   : synchronous clear of match_count only
//   match       : one-cycle pulse per detected pattern (registered or combinational)
//   match_count : saturating number of matches since reset/clear
//   state_o     : current prefix-length state, for debug
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            ST_W    = clog2(PAT_W + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             en,
  input  logic             x_in,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [ST_W-1:0]  state_o
);

  localparam logic [MAX_PAT_W-1:0] PAT16 = MAX_PAT_W'(PATTERN);
  // State to resume from after a complete match.
  localparam int FOLD = (OVERLAP == OVERLAP_ON) ? border(PAT16, PAT_W, PAT_W) : 0;

  // Transition table covers every encoding; illegal states map to 0.
  logic [ST_W-1:0] nxt_tab [2**ST_W][2];

  for (genvar s = 0; s < 2**ST_W; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int NS  = next_state(PAT16, PAT_W, s, 1'(b));
      localparam int NSF = (NS == PAT_W) ? FOLD : NS;
      assign nxt_tab[s][b] = ST_W'(NSF);
    end
  end

  logic [ST_W-1:0] state_p0;
  logic [ST_W-1:0] state_next;
  logic            hit;

  always_comb begin
    state_next = state_p0;
    hit        = 1'b0;
    if (en) begin
      state_next = nxt_tab[state_p0][x_in];
      // A completing bit seen together with CLR is discarded with the partial pattern.
      hit        = !CLR && (state_p0 == ST_W'(PAT_W - 1)) && (x_in == PATTERN[0]);
    end
  end

  // Stage p0: state register
  always_ff @(posedge CLK) begin
    if (CLR) state_p0 <= '0;
    else     state_p0 <= state_next;
  end

  assign state_o = state_p0;

  // Stage p1: match output
  if (MOORE == MODE_MOORE) begin : g_moore
    logic match_p1;
    always_ff @(posedge CLK) begin
      if (CLR) match_p1 <= 1'b0;
      else     match_p1 <= hit;
    end
    assign match = match_p1;
  end else begin : g_mealy
    assign match = hit;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .CLK  (CLK),
    .CLR  (CLR),
    .inc  (hit),
    .clr  (clr_count),
    .count(match_count)
  );

endmodule
